// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan driver: hex decode, decimal points, double-buffered data,
// leading-zero blanking and PWM brightness. Outputs are registered (one cycle behind the slot counter).
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 25000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lzs_en,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [7:0]              segData,
    output logic [NUM_DIGITS-1:0]   segCtl,
    output logic                    frame_done
);
    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W  = CNT_W + BRIGHT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [4*NUM_DIGITS-1:0] r_act;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_pend_vld;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_ctl;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [ON_W-1:0]         w_on_prod;
    logic [ON_W-1:0]         w_on_cyc;
    logic                    w_lit;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_lead_zero;
    logic [3:0]              w_code;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_ctl_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] code);
        case (code)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);

    // On-time in cycles; the ghost cycle at cnt==0 is always dark on top of this.
    assign w_on_prod  = (ON_W'(bright) + ON_W'(1)) * ON_W'(SLOT_CYC);
    assign w_on_cyc   = w_on_prod >> BRIGHT_W;
    assign w_lit      = (r_cnt != '0) && (ON_W'(r_cnt) < w_on_cyc);

    // w_lead_zero[i]: digit i and every more-significant digit hold code 0.
    always_comb begin
        w_lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lead_zero[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (r_act[4*j +: 4] != 4'h0) begin
                    w_lead_zero[i] = 1'b0;
                end
            end
        end
    end

    assign w_code  = r_act[4*r_idx +: 4];
    assign w_glyph = hex_glyph(w_code);
    assign w_blank = lzs_en && (r_idx != '0) && w_lead_zero[r_idx];

    always_comb begin
        w_seg_nxt = 8'hFF;
        w_ctl_nxt = '0;
        if (w_lit) begin
            w_ctl_nxt[r_idx] = 1'b1;
            w_seg_nxt = {~r_act_dp[r_idx], (w_blank ? 7'h7F : w_glyph)};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_vld   <= 1'b0;
            r_act        <= '0;
            r_act_dp     <= '0;
            r_seg        <= 8'hFF;
            r_ctl        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Frame start promotes the old pending data even if a new load lands on the same edge.
            if (w_wrap && r_pend_vld) begin
                r_act    <= r_pend;
                r_act_dp <= r_pend_dp;
            end
            if (load) begin
                r_pend     <= digits;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end else if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end
            r_frame_done <= w_wrap;
            r_ctl        <= w_ctl_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign segData    = r_seg;
    assign segCtl     = r_ctl;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 3-bit brightness).
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int BW    = 3;
    localparam int FRAME = ND * SC;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        lzs_en = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [7:0]  segData;
    logic [3:0]  segCtl;
    logic        frame_done;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYC(SC), .BRIGHT_W(BW)) dut (
        .CLK(CLK), .RST(RST), .digits(digits), .dp_in(dp_in), .load(load),
        .lzs_en(lzs_en), .bright(bright), .segData(segData), .segCtl(segCtl),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] ctl;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pend_dp, m_act_dp;
    logic        m_pv;
    logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic exp_t model_out(input int s, input logic [15:0] act, input logic [3:0] adp,
                                       input logic lz, input logic [2:0] br);
        exp_t r;
        int c, ix, on;
        logic [15:0] hi;
        logic [3:0] code;
        c  = s % SC;
        ix = (s / SC) % ND;
        on = ((int'(br) + 1) * SC) >> BW;
        r = '0;
        r.seg = 8'hFF;
        if (c != 0 && c < on) begin
            r.ctl = 4'b0001 << ix;
            hi = act >> (4 * ix);
            code = hi[3:0];
            r.seg = seg_tbl[code];
            if (lz && ix != 0 && hi == 16'h0) r.seg = 8'hFF;
            if (adp[ix]) r.seg[7] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_t = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0; m_pv = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle at a negedge, push the output expected after the next posedge.
    task automatic drive_cycle(input logic ld, input logic [15:0] d, input logic [3:0] dpv);
        exp_t e;
        load = ld; digits = d; dp_in = dpv;
        e = model_out(m_t, m_act, m_act_dp, lzs_en, bright);
        e.fd = ((m_t + 1) % FRAME == 0);
        sb.push_back(e);
        if ((m_t + 1) % FRAME == 0 && m_pv) begin
            m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0;
        end
        if (ld) begin
            m_pend = d; m_pend_dp = dpv; m_pv = 1'b1;
        end
        @(negedge CLK);
        load = 1'b0;
        m_t++;
    endtask

    task automatic test_reset();
        exp_t e;
        #1 RST = 1'b1;
        #3;
        n_checks++; if (segData !== 8'hFF) begin n_fail++; $display("FAIL por_seg got=%h exp=ff", segData); end
        n_checks++; if (segCtl !== 4'h0) begin n_fail++; $display("FAIL por_ctl got=%b exp=0000", segCtl); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL por_fd got=%b exp=0", frame_done); end
        @(negedge CLK); RST = 1'b0; model_reset();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(i == 5, 16'h4321, 4'h0);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL reset_run t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
            if (i == 1) begin
                n_checks++;
                if (segCtl !== 4'b0001) begin n_fail++; $display("FAIL first_lit got=%b exp=0001", segCtl); end
            end
        end
        #2 RST = 1'b1;
        #1;
        n_checks++; if (segData !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_seg got=%h exp=ff", segData); end
        n_checks++; if (segCtl !== 4'h0) begin n_fail++; $display("FAIL mid_rst_ctl got=%b exp=0000", segCtl); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fd got=%b exp=0", frame_done); end
        @(negedge CLK); RST = 1'b0; model_reset();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 16'h0, 4'h0);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL after_rst t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int start, fd_cnt;
        logic done_ld;
        bright = 3'd7; lzs_en = 1'b0; done_ld = 1'b0; fd_cnt = 0; start = m_t;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(!done_ld && (m_t % FRAME == 10), 16'h4321, 4'h0);
            if (m_t % FRAME == 11) done_ld = 1'b1;
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL scan t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
            if (frame_done) fd_cnt++;
        end
        n_checks++;
        if (fd_cnt != (m_t / FRAME) - (start / FRAME)) begin
            n_fail++; $display("FAIL frame_done_count got=%0d exp=%0d", fd_cnt, (m_t / FRAME) - (start / FRAME));
        end
    endtask

    task automatic test_double_buffer();
        exp_t e;
        int base, rel, orel, n_f9, n_a4;
        base = m_t / FRAME + 1; n_f9 = 0; n_a4 = 0;
        while (m_t < (base + 3) * FRAME) begin
            rel = m_t / FRAME - base;
            drive_cycle(rel == 0 && (m_t % FRAME == 5 || m_t % FRAME == 20),
                        (m_t % FRAME == 5) ? 16'h1111 : 16'h2222, 4'h0);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL dbuf t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
            orel = (m_t - 1) / FRAME - base;
            if (orel == 1 && segData == 8'hF9) n_f9++;
            if (orel == 1 && segData == 8'hA4) n_a4++;
        end
        n_checks++; if (n_f9 != 0) begin n_fail++; $display("FAIL dbuf_1111_shown got=%0d exp=0", n_f9); end
        n_checks++; if (n_a4 != 28) begin n_fail++; $display("FAIL dbuf_2222_cycles got=%0d exp=28", n_a4); end
    endtask

    task automatic test_lzs();
        exp_t e;
        lzs_en = 1'b1;
        for (int i = 0; i < 110; i++) begin
            if (i == 75) lzs_en = 1'b0;
            drive_cycle(i == 0, 16'h0050, 4'b1000);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL lzs t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
        end
    endtask

    task automatic test_brightness();
        exp_t e;
        int lit;
        logic [2:0] lvl [3];
        lvl[0] = 3'd1; lvl[1] = 3'd3; lvl[2] = 3'd7;
        while (m_t % FRAME != 0) begin
            drive_cycle(1'b0, 16'h0, 4'h0);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL bright_align t=%0d got ctl=%b seg=%h exp ctl=%b seg=%h",
                         m_t, segCtl, segData, e.ctl, e.seg);
            end
        end
        for (int k = 0; k < 3; k++) begin
            bright = lvl[k]; lit = 0;
            for (int i = 0; i < FRAME; i++) begin
                drive_cycle(1'b0, 16'h0, 4'h0);
                e = sb.pop_front();
                n_checks++;
                if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                    n_fail++;
                    $display("FAIL bright t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                             m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
                end
                if (segCtl != 4'h0) lit++;
            end
            n_checks++;
            if (lit != 4 * int'(lvl[k])) begin
                n_fail++; $display("FAIL bright_lit level=%0d got=%0d exp=%0d", lvl[k], lit, 4 * int'(lvl[k]));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        int base, rel, orel, n5, n6;
        logic ld;
        logic [15:0] d;
        base = m_t / FRAME + 1; n5 = 0; n6 = 0;
        while (m_t < (base + 3) * FRAME) begin
            rel = m_t / FRAME - base;
            ld = (rel == 0) && (m_t % FRAME == 10 || m_t % FRAME == FRAME - 1);
            d = (m_t % FRAME == 10) ? 16'h5555 : 16'h6666;
            drive_cycle(ld, d, 4'h0);
            e = sb.pop_front();
            n_checks++;
            if ({segCtl, segData, frame_done} !== {e.ctl, e.seg, e.fd}) begin
                n_fail++;
                $display("FAIL wrap_load t=%0d got ctl=%b seg=%h fd=%b exp ctl=%b seg=%h fd=%b",
                         m_t, segCtl, segData, frame_done, e.ctl, e.seg, e.fd);
            end
            orel = (m_t - 1) / FRAME - base;
            if (orel == 1 && segData == 8'h92) n5++;
            if (orel == 2 && segData == 8'h82) n6++;
        end
        n_checks++; if (n5 != 28) begin n_fail++; $display("FAIL wrap_old_pending got=%0d exp=28", n5); end
        n_checks++; if (n6 != 28) begin n_fail++; $display("FAIL wrap_new_next got=%0d exp=28", n6); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_buffer();
        test_lzs();
        test_brightness();
        test_load_on_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
